// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue
//   Fetch front end. Owns the fetch PC, pulls FETCH_WIDTH contiguous words
//   per cycle from instruction memory into a DEPTH-entry circular queue, and
//   presents the ISSUE_WIDTH oldest entries (instruction + PC) to issue.
//   A redirect flushes the queue and restarts fetch at the new PC.
//
// Optional feature: define IFQ_BYPASS_EN to let words being fetched this
//   cycle appear on the dequeue slots combinationally when the queue holds
//   fewer than ISSUE_WIDTH entries.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_addr         byte address of fetch-group word 0 (from fetch PC)
//   imem_data         FETCH_WIDTH words starting at imem_addr
//   redirect_valid    flush and restart fetch at redirect_pc (word aligned)
//   deq_valid         per-slot valid, contiguous from slot 0
//   deq_instr/deq_pc  slot contents, slot 0 = oldest; zero when invalid
//   deq_take          number of slots consumed this cycle (clipped to valid)
//   occupancy         registered entry count

// One presented slot: picks stored or bypassed data and zeroes it when idle.
module ifq_slot (
    input  logic        valid,
    input  logic        byp_sel,
    input  logic [31:0] mem_instr,
    input  logic [31:0] mem_pc,
    input  logic [31:0] byp_instr,
    input  logic [31:0] byp_pc,
    output logic [31:0] instr,
    output logic [31:0] pc
);
    always_comb begin
        instr = '0;
        pc    = '0;
        if (valid) begin
            instr = byp_sel ? byp_instr : mem_instr;
            pc    = byp_sel ? byp_pc    : mem_pc;
        end
    end
endmodule

module instruction_fetch_queue #(
    parameter int          FETCH_WIDTH     = 2,
    parameter int          ISSUE_WIDTH     = 2,
    parameter int          DEPTH           = 8,
    parameter logic [31:0] START_BYTE_ADDR = 32'h0000_3000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    output logic [31:0]                            imem_addr,
    input  logic [FETCH_WIDTH-1:0][31:0]           imem_data,
    input  logic                                   redirect_valid,
    input  logic [31:0]                            redirect_pc,
    output logic [ISSUE_WIDTH-1:0]                 deq_valid,
    output logic [ISSUE_WIDTH-1:0][31:0]           deq_instr,
    output logic [ISSUE_WIDTH-1:0][31:0]           deq_pc,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]       deq_take,
    output logic [$clog2(DEPTH+1)-1:0]             occupancy
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int TAKE_W = $clog2(ISSUE_WIDTH+1);
    // Visible count can exceed DEPTH by a fetch group when bypassing.
    localparam int VIS_W  = $clog2(DEPTH+FETCH_WIDTH+1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;

    logic               enq;
    logic               byp_act;
    logic [VIS_W-1:0]   n_vis;
    logic [TAKE_W-1:0]  n_slots, take_eff, byp_taken, stored_take;
    logic [CNT_W-1:0]   enq_words;

    assign imem_addr = fetch_pc;
    assign occupancy = count;

    always_comb begin
        // Free space is judged before this cycle's dequeue so enqueue never
        // waits on the issue stage's take decision.
        enq = !redirect_valid && (count <= CNT_W'(DEPTH - FETCH_WIDTH));
`ifdef IFQ_BYPASS_EN
        byp_act = enq && (count < CNT_W'(ISSUE_WIDTH));
`else
        byp_act = 1'b0;
`endif
        n_vis   = VIS_W'(count) + (byp_act ? VIS_W'(FETCH_WIDTH) : '0);
        n_slots = (n_vis > VIS_W'(ISSUE_WIDTH)) ? TAKE_W'(ISSUE_WIDTH) : TAKE_W'(n_vis);
        take_eff = (deq_take > n_slots) ? n_slots : deq_take;
        // Stored entries are older than bypassed ones, so a take drains the
        // stored part first and only the overflow consumes fetched words.
        byp_taken = '0;
        if (byp_act && (VIS_W'(take_eff) > VIS_W'(count)))
            byp_taken = TAKE_W'(VIS_W'(take_eff) - VIS_W'(count));
        stored_take = take_eff - byp_taken;
        enq_words   = enq ? (CNT_W'(FETCH_WIDTH) - CNT_W'(byp_taken)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= START_BYTE_ADDR;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                tail     <= tail + PTR_W'(enq_words);
                fetch_pc <= fetch_pc + 32'(4 * FETCH_WIDTH);
            end
            head  <= head + PTR_W'(stored_take);
            count <= count + enq_words - CNT_W'(stored_take);
        end
    end

    // Storage carries no reset; slot outputs are masked by validity instead.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int k = 0; k < FETCH_WIDTH; k++) begin
                if (k >= int'(byp_taken))
                    mem[tail + PTR_W'(k) - PTR_W'(byp_taken)] <=
                        '{instr: imem_data[k], pc: fetch_pc + 32'(4 * k)};
            end
        end
    end

    for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
        logic [PTR_W-1:0] rd_idx;
        logic             byp_sel;
        logic [31:0]      byp_instr, byp_pc;

        assign rd_idx       = head + PTR_W'(s);
        assign deq_valid[s] = VIS_W'(s) < n_vis;

        // Slots at or beyond the stored count show fetch word (s - count).
        always_comb begin
            byp_sel   = byp_act && (CNT_W'(s) >= count);
            byp_instr = '0;
            byp_pc    = '0;
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (int'(count) + j == s) begin
                    byp_instr = imem_data[j];
                    byp_pc    = fetch_pc + 32'(4 * j);
                end
            end
        end

        ifq_slot u_slot (
            .valid     (deq_valid[s]),
            .byp_sel   (byp_sel),
            .mem_instr (mem[rd_idx].instr),
            .mem_pc    (mem[rd_idx].pc),
            .byp_instr (byp_instr),
            .byp_pc    (byp_pc),
            .instr     (deq_instr[s]),
            .pc        (deq_pc[s])
        );
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Testbench for instruction_fetch_queue: directed scenarios plus randomized
// take/redirect traffic, checked against a queue-of-PCs reference model.
module tb_instruction_fetch_queue;
    localparam int          FW    = 2;
    localparam int          IW    = 2;
    localparam int          D     = 8;
    localparam logic [31:0] START = 32'h0000_3000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          imem_addr;
    logic [FW-1:0][31:0]  imem_data;
    logic                 redirect_valid = 1'b0;
    logic [31:0]          redirect_pc = '0;
    logic [IW-1:0]        deq_valid;
    logic [IW-1:0][31:0]  deq_instr, deq_pc;
    logic [1:0]           deq_take = '0;
    logic [3:0]           occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued PCs in age order plus the fetch PC.
    logic [31:0] mq[$];
    logic [31:0] mpc;
    int          m_take;
    bit          m_redir;
    logic [31:0] m_rpc;

    logic [IW-1:0]       exp_valid;
    logic [IW-1:0][31:0] exp_pc, exp_instr;
    int                  exp_occ;
    logic [31:0]         exp_addr;

    instruction_fetch_queue #(
        .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(D), .START_BYTE_ADDR(START)
    ) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_instr(deq_instr), .deq_pc(deq_pc),
        .deq_take(deq_take), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678 ^ {a[15:0], a[31:16]};
    endfunction

    always_comb
        for (int k = 0; k < FW; k++) imem_data[k] = mem_word(imem_addr + 32'(4 * k));

    function automatic bit model_enq();
        return !m_redir && (D - mq.size() >= FW);
    endfunction

    function automatic int vis_count();
        int n = mq.size();
`ifdef IFQ_BYPASS_EN
        if (model_enq() && n < IW) n += FW;
`endif
        return n;
    endfunction

    function automatic logic [31:0] vis_pc(input int i);
        if (i < mq.size()) return mq[i];
        return mpc + 32'(4 * (i - mq.size()));
    endfunction

    // Apply inputs just after a rising edge, predict outputs, go to the falling edge.
    task automatic drive(input int take, input bit redir, input logic [31:0] rpc);
        deq_take = 2'(take); redirect_valid = redir; redirect_pc = rpc;
        m_take = take; m_redir = redir; m_rpc = rpc;
        exp_valid = '0; exp_pc = '0; exp_instr = '0;
        for (int s = 0; s < IW; s++) begin
            if (s < vis_count()) begin
                exp_valid[s] = 1'b1;
                exp_pc[s]    = vis_pc(s);
                exp_instr[s] = mem_word(exp_pc[s]);
            end
        end
        exp_occ  = mq.size();
        exp_addr = mpc;
        @(negedge clk);
    endtask

    // Advance one rising edge and apply the same inputs to the model.
    task automatic tick();
        int te;
        bit e;
        @(posedge clk);
        if (m_redir) begin
            mq.delete();
            mpc = m_rpc & 32'hFFFF_FFFC;
        end else begin
            e  = model_enq();
            te = m_take;
            if (te > vis_count()) te = vis_count();
            if (te > IW) te = IW;
            if (e) begin
                for (int k = 0; k < FW; k++) mq.push_back(mpc + 32'(4 * k));
                mpc = mpc + 32'(4 * FW);
            end
            repeat (te) void'(mq.pop_front());
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = START;
        m_redir = 1'b0;
        m_take = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; deq_take = '0; redirect_valid = 1'b0;
        #12;
        n_checks++; if (imem_addr !== START) begin n_fail++; $display("FAIL reset_addr got %h want %h", imem_addr, START); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_checks++; if (deq_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b want 00", deq_valid); end
        n_checks++; if (deq_pc !== '0 || deq_instr !== '0) begin n_fail++; $display("FAIL reset_data got pc %h instr %h want 0", deq_pc, deq_instr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Hold take=0 until full: 4 groups of 2 words, fetch PC advances 32 bytes.
    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin drive(0, 0, '0); tick(); end
        drive(0, 0, '0);
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occ got %0d want 8", occupancy); end
        n_checks++; if (imem_addr !== START + 32'h20) begin n_fail++; $display("FAIL fill_addr got %h want %h", imem_addr, START + 32'h20); end
        n_checks++; if (deq_pc[0] !== START || deq_pc[1] !== START + 32'h4) begin n_fail++; $display("FAIL fill_pc got %h want %h %h", deq_pc, START + 32'h4, START); end
        n_checks++; if (deq_instr[0] !== mem_word(START) || deq_valid !== 2'b11) begin n_fail++; $display("FAIL fill_slot0 got %h/%b want %h/11", deq_instr[0], deq_valid, mem_word(START)); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (imem_addr !== START + 32'h20 || occupancy !== 4'd8) begin n_fail++; $display("FAIL full_stall got %h/%0d want %h/8", imem_addr, occupancy, START + 32'h20); end
        tick();
    endtask

    task automatic test_drain_one();
        drive(2, 0, '0); tick();
        drive(0, 0, '0);
        n_checks++; if (occupancy !== 4'd6) begin n_fail++; $display("FAIL drain_occ got %0d want 6", occupancy); end
        n_checks++; if (deq_pc[0] !== START + 32'h8 || deq_pc[1] !== START + 32'hC) begin n_fail++; $display("FAIL drain_pc got %h want %h %h", deq_pc, START + 32'hC, START + 32'h8); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (occupancy !== 4'd8 || imem_addr !== START + 32'h28) begin n_fail++; $display("FAIL refill got %0d/%h want 8/%h", occupancy, imem_addr, START + 32'h28); end
        tick();
    endtask

    // take=2 every cycle: slot 0 walks by 8 bytes with no gaps across the wrap.
    task automatic test_steady();
        for (int i = 0; i < 12; i++) begin
            drive(2, 0, '0);
            n_checks++; if (deq_pc[0] !== START + 32'h8 + 32'(8 * i)) begin n_fail++; $display("FAIL steady_pc%0d got %h want %h", i, deq_pc[0], START + 32'h8 + 32'(8 * i)); end
            n_checks++; if (occupancy !== 4'(exp_occ)) begin n_fail++; $display("FAIL steady_occ%0d got %0d want %0d", i, occupancy, exp_occ); end
            tick();
        end
    endtask

    task automatic test_redirect();
        drive(2, 1, 32'h0000_3043); tick();
        drive(0, 0, '0);
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL redir_occ got %0d want 0", occupancy); end
        n_checks++; if (imem_addr !== 32'h0000_3040) begin n_fail++; $display("FAIL redir_addr got %h want 00003040", imem_addr); end
        n_checks++; if (deq_valid !== exp_valid) begin n_fail++; $display("FAIL redir_valid got %b want %b", deq_valid, exp_valid); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (deq_pc[0] !== 32'h0000_3040 || !deq_valid[0]) begin n_fail++; $display("FAIL redir_pc got %h/%b want 00003040/1", deq_pc[0], deq_valid[0]); end
        tick();
    endtask

    // Take more than is valid: empty queue, then 2 valid with take=3.
    task automatic test_clip();
        drive(1, 1, 32'h0000_5001); tick();
        drive(2, 0, '0); tick();
        drive(3, 0, '0);
        n_checks++; if (occupancy !== 4'(exp_occ)) begin n_fail++; $display("FAIL clip_empty_occ got %0d want %0d", occupancy, exp_occ); end
        n_checks++; if (deq_valid !== exp_valid || deq_pc !== exp_pc) begin n_fail++; $display("FAIL clip_slots got %b/%h want %b/%h", deq_valid, deq_pc, exp_valid, exp_pc); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (occupancy !== 4'(exp_occ)) begin n_fail++; $display("FAIL clip_occ got %0d want %0d", occupancy, exp_occ); end
        n_checks++; if (deq_pc[0] !== exp_pc[0]) begin n_fail++; $display("FAIL clip_pc got %h want %h", deq_pc[0], exp_pc[0]); end
        tick();
    endtask

    task automatic test_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bit rd;
            rd = ($urandom_range(0, 15) == 0);
            drive(int'($urandom_range(0, 3)), rd, $urandom);
            n_checks++; if (deq_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", i, deq_valid, exp_valid); end
            n_checks++; if (deq_pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc c%0d got %h want %h", i, deq_pc, exp_pc); end
            n_checks++; if (deq_instr !== exp_instr) begin n_fail++; $display("FAIL rnd_instr c%0d got %h want %h", i, deq_instr, exp_instr); end
            n_checks++; if (occupancy !== 4'(exp_occ) || imem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_state c%0d got %0d/%h want %0d/%h", i, occupancy, imem_addr, exp_occ, exp_addr); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (occupancy !== 4'd0 || deq_valid !== 2'b00 || imem_addr !== START) begin n_fail++; $display("FAIL midrst_async got %0d/%b/%h want 0/00/%h", occupancy, deq_valid, imem_addr, START); end
        deq_take = '0; redirect_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        drive(0, 0, '0); tick();
        drive(0, 0, '0);
        n_checks++; if (deq_pc[0] !== START || occupancy !== 4'd2) begin n_fail++; $display("FAIL midrst_fetch got %h/%0d want %h/2", deq_pc[0], occupancy, START); end
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_drain_one();
        test_steady();
        test_redirect();
        test_clip();
        test_random(300);
        test_reset_mid();
        test_random(100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
